// File: rtl/udiv_8by4_if.sv
// Handshake and result bundle for the 8-by-4 sequential divider.
// start is a request sampled only while busy=0; done pulses once per result.
interface udiv_8by4_if;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/udiv_8by4.sv
// Restoring divider: 8-bit dividend / 4-bit divisor, one quotient bit per clock.
// Optional macro UDIV_ZERO_TRAP_EN adds a 1-cycle divide-by-zero exit through FIN.
module udiv_8by4 (
    input  logic              clk,
    input  logic              rst_n,
    udiv_8by4_if.slave        div_if,
    output logic [1:0]        state_o
);

    // Handshake: an edge with start=1 and busy=0 accepts and captures the operands;
    // start seen while busy=1 is dropped, and done marks the edge results changed.
`ifdef UDIV_ZERO_TRAP_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIN = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1} state_t;
`endif

    state_t     state_q, state_d;
    logic [7:0] dvd_q, dvd_d;
    logic [3:0] dvs_q, dvs_d;
    logic [3:0] racc_q, racc_d;
    logic [7:0] qacc_q, qacc_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] quot_q, quot_d;
    logic [3:0] rem_q, rem_d;
    logic       done_q, done_d;
`ifdef UDIV_ZERO_TRAP_EN
    logic       dbz_q, dbz_d;
`endif

    logic       accept;
    logic       last_iter;
    logic [4:0] r5;
    logic [4:0] r5_sub;
    logic       q_bit;
    logic [3:0] r_next;

    assign accept    = div_if.start && (state_q == S_IDLE);
    assign last_iter = (cnt_q == 3'd7);

    // Dividend register shifts left, so bit 7 is always the next bit to bring down.
    assign r5     = {racc_q, dvd_q[7]};
    assign q_bit  = (r5 >= {1'b0, dvs_q});
    assign r5_sub = r5 - {1'b0, dvs_q};
    assign r_next = q_bit ? r5_sub[3:0] : r5[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
`ifdef UDIV_ZERO_TRAP_EN
                if (accept) state_d = (div_if.divisor == 4'd0) ? S_FIN : S_RUN;
`else
                if (accept) state_d = S_RUN;
`endif
            end
            S_RUN:  if (last_iter) state_d = S_IDLE;
`ifdef UDIV_ZERO_TRAP_EN
            S_FIN:  state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        dvd_d  = dvd_q;
        dvs_d  = dvs_q;
        racc_d = racc_q;
        qacc_d = qacc_q;
        cnt_d  = cnt_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        done_d = 1'b0;
`ifdef UDIV_ZERO_TRAP_EN
        dbz_d  = dbz_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    dvd_d  = div_if.dividend;
                    dvs_d  = div_if.divisor;
                    racc_d = 4'd0;
                    qacc_d = 8'd0;
                    cnt_d  = 3'd0;
`ifdef UDIV_ZERO_TRAP_EN
                    if (div_if.divisor != 4'd0) dbz_d = 1'b0;
`endif
                end
            end
            S_RUN: begin
                dvd_d  = {dvd_q[6:0], 1'b0};
                racc_d = r_next;
                qacc_d = {qacc_q[6:0], q_bit};
                cnt_d  = cnt_q + 3'd1;
                if (last_iter) begin
                    quot_d = {qacc_q[6:0], q_bit};
                    rem_d  = r_next;
                    done_d = 1'b1;
                end
            end
`ifdef UDIV_ZERO_TRAP_EN
            S_FIN: begin
                quot_d = 8'hFF;
                rem_d  = dvd_q[3:0];
                dbz_d  = 1'b1;
                done_d = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_q  <= 8'd0;
            dvs_q  <= 4'd0;
            racc_q <= 4'd0;
            qacc_q <= 8'd0;
            cnt_q  <= 3'd0;
            quot_q <= 8'd0;
            rem_q  <= 4'd0;
            done_q <= 1'b0;
`ifdef UDIV_ZERO_TRAP_EN
            dbz_q  <= 1'b0;
`endif
        end else begin
            dvd_q  <= dvd_d;
            dvs_q  <= dvs_d;
            racc_q <= racc_d;
            qacc_q <= qacc_d;
            cnt_q  <= cnt_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            done_q <= done_d;
`ifdef UDIV_ZERO_TRAP_EN
            dbz_q  <= dbz_d;
`endif
        end
    end

    always_comb begin
        div_if.busy      = (state_q != S_IDLE);
        div_if.done      = done_q;
        div_if.quotient  = quot_q;
        div_if.remainder = rem_q;
`ifdef UDIV_ZERO_TRAP_EN
        div_if.div_by_zero = dbz_q;
`else
        div_if.div_by_zero = 1'b0;
`endif
        state_o = state_q;
    end

endmodule

// File: tb/tb_udiv_8by4.sv
// Self-checking bench for udiv_8by4: vector table, corner sequences, random traffic
// and an exhaustive held-start sweep, all scored against an arithmetic model.
module tb_udiv_8by4;

    localparam int W = 44;  // {dividend, divisor, accept cycle}
`ifdef UDIV_ZERO_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] state_dbg;

    udiv_8by4_if div_if ();

    udiv_8by4 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .div_if  (div_if.slave),
        .state_o (state_dbg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    int           cyc = 0;
    int           n_acc = 0;
    int           n_done = 0;
    logic [7:0]   last_q = 8'd0;
    logic [3:0]   last_r = 4'd0;
    logic         last_dbz = 1'b0;

    typedef struct {
        logic [7:0] dvd;
        logic [3:0] dvs;
        logic [7:0] q;
        logic [3:0] r;
        string      name;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] ref_div(input logic [7:0] a, input logic [3:0] b);
        int ai, bi;
        ai = a;
        bi = b;
        if (bi == 0) return {8'hFF, a[3:0]};
        return {8'(ai / bi), 4'(ai % bi)};
    endfunction

    // Scoreboard: observe at negedge, where inputs and outputs are stable.
    always @(negedge clk) begin
        logic [W-1:0] item;
        logic [11:0]  res;
        int           acc_cyc, ai, bi, qi, ri;
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            last_q   = 8'd0;
            last_r   = 4'd0;
            last_dbz = 1'b0;
            check("reset_outputs",
                  {div_if.busy, div_if.done, div_if.quotient, div_if.remainder, div_if.div_by_zero},
                  32'd0);
        end else begin
            if (div_if.done) begin
                n_done++;
                check("done_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    item    = exp_q.pop_front();
                    ai      = item[43:36];
                    bi      = item[35:32];
                    acc_cyc = item[31:0];
                    res      = ref_div(item[43:36], item[35:32]);
                    last_q   = res[11:4];
                    last_r   = res[3:0];
                    last_dbz = TRAP && (bi == 0);
                    check("latency", cyc - acc_cyc - 1, (TRAP && bi == 0) ? 1 : 8);
                    if (bi != 0) begin
                        qi = div_if.quotient;
                        ri = div_if.remainder;
                        check("identity", {31'd0, (qi * bi + ri == ai) && (ri < bi)}, 32'd1);
                    end
                end
            end
            check("result", {div_if.quotient, div_if.remainder, div_if.div_by_zero},
                  {last_q, last_r, last_dbz});
            check("busy", div_if.busy, exp_q.size() != 0);
            if (div_if.start && exp_q.size() == 0) begin
                exp_q.push_back({div_if.dividend, div_if.divisor, 32'(cyc)});
                n_acc++;
                if (TRAP && div_if.divisor != 4'd0) last_dbz = 1'b0;
            end
        end
    end

    task automatic wait_done(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (div_if.done) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    // Called just after a rising edge with the divider idle.
    task automatic run_one(input vec_t v);
        bit got;
        div_if.start    = 1'b1;
        div_if.dividend = v.dvd;
        div_if.divisor  = v.dvs;
        @(posedge clk); #1;
        div_if.start    = 1'b0;
        div_if.dividend = 8'($urandom);
        div_if.divisor  = 4'($urandom);
        wait_done(20, got);
        check({v.name, "_done"}, {31'd0, got}, 32'd1);
        check({v.name, "_q"}, div_if.quotient, v.q);
        check({v.name, "_r"}, div_if.remainder, v.r);
        check({v.name, "_dbz"}, div_if.div_by_zero, TRAP && (v.dvs == 4'd0));
        @(posedge clk); #1;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[8];
        bit   got;
        int   ndone, acc0, done0;

        vecs[0] = '{8'd200, 4'd7,  8'd28,  4'd4, "v200_7"};
        vecs[1] = '{8'd255, 4'd15, 8'd17,  4'd0, "v255_15"};
        vecs[2] = '{8'd0,   4'd5,  8'd0,   4'd0, "v0_5"};
        vecs[3] = '{8'd9,   4'd10, 8'd0,   4'd9, "v9_10"};
        vecs[4] = '{8'd15,  4'd1,  8'd15,  4'd0, "v15_1"};
        vecs[5] = '{8'd13,  4'd0,  8'hFF,  4'hD, "v13_0"};
        vecs[6] = '{8'd77,  4'd6,  8'd12,  4'd5, "v77_6"};
        vecs[7] = '{8'd128, 4'd9,  8'd14,  4'd2, "v128_9"};

        div_if.start    = 1'b0;
        div_if.dividend = 8'd0;
        div_if.divisor  = 4'd0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_one(vecs[i]);

        // Second request arriving mid-division must be dropped, not queued.
        div_if.start = 1'b1; div_if.dividend = 8'd100; div_if.divisor = 4'd3;
        @(posedge clk); #1;
        div_if.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        div_if.start = 1'b1; div_if.dividend = 8'd50; div_if.divisor = 4'd2;
        @(posedge clk); #1;
        div_if.start = 1'b0;
        wait_done(20, got);
        check("ignored_done", {31'd0, got}, 32'd1);
        check("ignored_q", div_if.quotient, 8'd33);
        check("ignored_r", div_if.remainder, 4'd1);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (div_if.done) ndone++;
        end
        check("no_queued_start", ndone, 0);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a division.
        div_if.start = 1'b1; div_if.dividend = 8'd200; div_if.divisor = 4'd7;
        @(posedge clk); #1;
        div_if.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check("async_reset",
                 {div_if.busy, div_if.done, div_if.quotient, div_if.remainder, div_if.div_by_zero},
                 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        run_one('{8'd77, 4'd6, 8'd12, 4'd5, "after_reset"});

        // Random traffic, including zero divisors and starts while busy.
        for (int i = 0; i < 600; i++) begin
            div_if.start    = ($urandom_range(0, 3) == 0);
            div_if.dividend = 8'($urandom_range(0, 255));
            div_if.divisor  = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            @(posedge clk); #1;
        end
        div_if.start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check("random_drain", exp_q.size(), 0);
        @(posedge clk); #1;

        // Exhaustive sweep with start held high.
        acc0  = n_acc;
        done0 = n_done;
        div_if.start = 1'b1;
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                div_if.dividend = 8'(a);
                div_if.divisor  = 4'(b);
                got = 1'b0;
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    if (!div_if.busy) begin
                        got = 1'b1;
                        break;
                    end
                end
                check("sweep_accept", {31'd0, got}, 32'd1);
                @(posedge clk); #1;
            end
        end
        div_if.start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check("sweep_drain", exp_q.size(), 0);
        check("sweep_accepts", n_acc - acc0, 3840);
        check("sweep_dones", n_done - done0, 3840);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
